control_unit_pipe: RTL and testbench
====================================

# control_unit_pipe

Parametrised pipelined control path for the five-stage RISC-V core. It decodes the D-stage instruction fields into control signals, then carries them through the E, M and W pipeline registers. The registers obey hazard-unit stall and flush, and bubbles never carry a write enable. It replaces the combinational D-stage decoder plus the hand-wired control slices of the ID/EX, EX/MEM and MEM/WB registers.

## Interface
- `ALU_CTRL_W`, default 3. ALU control width. 3 gives the base set; 4 adds the extended ALU ops.
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `validD`  in  1  D-stage instruction is real (not a bubble).
- `opD`  in  7  opcode.
- `funct3D`  in  3  funct3.
- `funct7_5D`  in  1  instr[30].
- `stallE`  in  1  hold E register (hazard unit also stalls F/D).
- `flushE`  in  1  turn E into a bubble next cycle.
- `imm_srcD`  out  2  immediate select, combinational from D.
- `reg_writeE, alu_srcE, branchE, jumpE, jalrE`  out  1 each.
- `funct3E`  out  3  branch condition select.
- `alu_controlE`  out  ALU_CTRL_W.
- `result_srcE`  out  2  for load-use detection.
- `reg_writeM, mem_writeM`  out  1.
- `result_srcM`  out  2.
- `reg_writeW`  out  1.
- `result_srcW`  out  2.
- `validE, validM, validW`  out  1.
- `illegalE`  out  1  illegal instruction in E.
- `illegal_seen`  out  1  sticky.

## Operation
- Main decode, keyed on `opD`:
  - 0000011 lw: reg_write, alu_src, result 01, imm I, alu_op 00.
  - 0100011 sw: mem_write, alu_src, imm S, alu_op 00.
  - 0110011 R-type: reg_write, alu_op 10.
  - 0010011 I-ALU: reg_write, alu_src, imm I, alu_op 10.
  - 1100011 branch: branch, imm B, alu_op 01.
  - 1101111 jal: reg_write, jump, result 10, imm J.
  - 1100111 jalr: reg_write, jump, jalr, alu_src, result 10, imm I, alu_op 00.
  - Any other opcode: all enables 0, and the instruction is illegal.
- imm_src encoding: 00 I, 01 S, 10 B, 11 J.
- result_src encoding: 00 ALU, 01 mem, 10 PC+4.
- ALU decode:
  - alu_op 00 → add 000.
  - alu_op 01 → sub 001.
  - alu_op 10, by funct3:
    - 000 → sub if {op[5], funct7_5} == 11, else add.
    - 010 → slt 101.
    - 110 → or 011.
    - 111 → and 010.
  - ALU_CTRL_W=4 adds, zero-extended base codes:
    - 100 → xor 0100.
    - 001 → sll 0110.
    - 101 → srl 0111, or sra 1000 when funct7_5 = 1.
    - 011 → sltu 1001.
  - ALU_CTRL_W=3: funct3 001/011/100/101 with alu_op 10 are illegal.
- Bubble rule: for any invalid stage, reg_write, mem_write, branch, jump, jalr and illegal read 0. Other fields are don't-care but deterministic (zero).
- `validD = 0` loads a bubble into E regardless of opD.

## Timing
- D→E register:
  - `flushE` → bubble; flush has priority over stall.
  - else `stallE` → hold.
  - else load the D decode.
- E→M register:
  - `stallE` high → M loads a bubble.
  - else M loads E.
- M→W register: always loads M.
- Latency: a D instruction appears at E after 1 cycle, M after 2, W after 3, absent stalls.
- Reset clears every stage register (all outputs 0, valid 0) and `illegal_seen`. Reset mid-stream discards all in-flight instructions.
- `imm_srcD` is purely combinational; no reset dependence.

## Configuration
- `CONTROL_ILLEGAL_TRAP_EN` defined:
  - `illegalE` = validE & illegal decode.
  - `illegal_seen` sets on the first cycle `illegalE` = 1 and stays set until reset.
  - An illegal instruction also has all its enables forced to 0.
- Undefined: `illegalE` and `illegal_seen` are tied 0, and no illegal-decode logic is built. Unknown opcodes still decode to all enables 0.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - imm_src, result_src, alu_op and alu_control localparams;
  - a packed control-bundle typedef (E fields), reused by the datapath pipeline registers.
- Sub-module `ctrl_decode`: combinational main + ALU decode parameterised by `ALU_CTRL_W`. The top holds only the three stage registers and the sticky flag.

## Test plan
- **Base sequence.** Reset, then validD=1 with lw (0000011), sw, R-add, beq on consecutive cycles.
  - Required: at E in order, reg_writeE 1/0/1/0, mem_write reaching M on cycle 3 for sw only, alu_controlE 000/000/000/001, branchE=1 for beq.
  - Required: lw result_srcW=01, 3 cycles after its D cycle.
- **ALU_CTRL_W=4 decode.** R-type funct3=101 with funct7_5=1 → alu_controlE=1000. With funct7_5=0 → 0111. I-type funct3=000, funct7_5=1 → 0000 (not sub).
- **Stall.** Hold stallE=1 two cycles with an R-add in E.
  - Required: E values unchanged, validM=0 for both cycles, reg_writeM=0.
  - Required: the add reaches M the cycle after stallE drops.
- **Flush priority.** flushE=1 with stallE=1 and jal in D → next cycle validE=0, jumpE=0, reg_writeE=0.
- **Illegal (macro on).** opD=1111111 valid → illegalE=1 next cycle, illegal_seen=1 the cycle after and held across further legal instructions until reset. With the macro off, both stay 0.
- **Reset mid-stream.** Assert reset with valid instructions in E/M/W → next cycle all valid and enable outputs 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcode, select encodings and the E-stage control bundle shared with the datapath
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Codes are stored at the widest configuration; narrower builds use the low bits.
  localparam int ALU_CTRL_MAX_W = 4;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      jalr;
    logic                      alu_src;
    logic [1:0]                result_src;
    logic [2:0]                funct3;
    logic [ALU_CTRL_MAX_W-1:0] alu_control;
  } ctrl_bundle_t;

  function automatic logic is_known_op(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// rtl/control_unit_pipe_if.sv - D-stage fields, hazard controls and staged control outputs
interface control_unit_pipe_if #(parameter int ALU_CTRL_W = 3);
  logic                  validD;
  logic [6:0]            opD;
  logic [2:0]            funct3D;
  logic                  funct7_5D;
  logic                  stallE;
  logic                  flushE;
  logic [1:0]            imm_srcD;
  logic                  reg_writeE;
  logic                  alu_srcE;
  logic                  branchE;
  logic                  jumpE;
  logic                  jalrE;
  logic [2:0]            funct3E;
  logic [ALU_CTRL_W-1:0] alu_controlE;
  logic [1:0]            result_srcE;
  logic                  reg_writeM;
  logic                  mem_writeM;
  logic [1:0]            result_srcM;
  logic                  reg_writeW;
  logic [1:0]            result_srcW;
  logic                  validE;
  logic                  validM;
  logic                  validW;
  logic                  illegalE;
  logic                  illegal_seen;

  modport master (
    output validD, opD, funct3D, funct7_5D, stallE, flushE,
    input  imm_srcD, reg_writeE, alu_srcE, branchE, jumpE, jalrE, funct3E,
    input  alu_controlE, result_srcE, reg_writeM, mem_writeM, result_srcM,
    input  reg_writeW, result_srcW, validE, validM, validW, illegalE, illegal_seen
  );

  modport slave (
    input  validD, opD, funct3D, funct7_5D, stallE, flushE,
    output imm_srcD, reg_writeE, alu_srcE, branchE, jumpE, jalrE, funct3E,
    output alu_controlE, result_srcE, reg_writeM, mem_writeM, result_srcM,
    output reg_writeW, result_srcW, validE, validM, validW, illegalE, illegal_seen
  );
endinterface

// File: rtl/control_unit_pipe_ctrl_decode.sv
// rtl/control_unit_pipe_ctrl_decode.sv - main and ALU decode; CONTROL_ILLEGAL_TRAP_EN adds illegal detection
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output ctrl_bundle_t ctrl,
`ifdef CONTROL_ILLEGAL_TRAP_EN
  output logic         illegal,
`endif
  output logic [1:0]   imm_src
);

  localparam bit EXT = (ALU_CTRL_W >= 4);

  ctrl_bundle_t raw;
  logic [1:0]   alu_op;
  logic [3:0]   alu_ctrl;

  always_comb begin
    raw     = '0;
    imm_src = IMM_I;
    alu_op  = ALUOP_ADD;
    case (op)
      OP_LOAD: begin
        raw.reg_write  = 1'b1;
        raw.alu_src    = 1'b1;
        raw.result_src = RES_MEM;
      end
      OP_STORE: begin
        raw.mem_write = 1'b1;
        raw.alu_src   = 1'b1;
        imm_src       = IMM_S;
      end
      OP_RTYPE: begin
        raw.reg_write = 1'b1;
        alu_op        = ALUOP_FUNCT;
      end
      OP_IALU: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        alu_op        = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        raw.branch = 1'b1;
        imm_src    = IMM_B;
        alu_op     = ALUOP_SUB;
      end
      OP_JAL: begin
        raw.reg_write  = 1'b1;
        raw.jump       = 1'b1;
        raw.result_src = RES_PC4;
        imm_src        = IMM_J;
      end
      OP_JALR: begin
        raw.reg_write  = 1'b1;
        raw.jump       = 1'b1;
        raw.jalr       = 1'b1;
        raw.alu_src    = 1'b1;
        raw.result_src = RES_PC4;
      end
      default: ;
    endcase
    raw.funct3      = funct3;
    raw.alu_control = alu_ctrl;
  end

  // Only R-type (op[5]=1) with instr[30] set subtracts; addi never does.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op[5] & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          3'b100:  alu_ctrl = EXT ? ALU_XOR : ALU_ADD;
          3'b001:  alu_ctrl = EXT ? ALU_SLL : ALU_ADD;
          3'b101:  alu_ctrl = EXT ? (funct7_5 ? ALU_SRA : ALU_SRL) : ALU_ADD;
          3'b011:  alu_ctrl = EXT ? ALU_SLTU : ALU_ADD;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic illegal_alu;
  assign illegal_alu = !EXT && (alu_op == ALUOP_FUNCT) &&
                       (funct3 inside {3'b001, 3'b011, 3'b100, 3'b101});
  assign illegal     = !is_known_op(op) || illegal_alu;
  assign ctrl        = illegal ? '0 : raw;
`else
  assign ctrl = raw;
`endif

endmodule

// File: rtl/control_unit_pipe.sv
// rtl/control_unit_pipe.sv - D decode plus E/M/W control registers; CONTROL_ILLEGAL_TRAP_EN enables illegal trap
module control_unit_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input logic                clk,
  input logic                reset,
  control_unit_pipe_if.slave bus
);

  ctrl_bundle_t d_ctrl;
  ctrl_bundle_t e_next;
  ctrl_bundle_t e_reg;
  logic [1:0]   imm_src;
  logic         m_valid, m_reg_write, m_mem_write;
  logic [1:0]   m_result_src;
  logic         w_valid, w_reg_write;
  logic [1:0]   w_result_src;

`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic d_illegal;
  logic e_illegal;
  logic seen;
`endif

  ctrl_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_decode (
    .op       (bus.opD),
    .funct3   (bus.funct3D),
    .funct7_5 (bus.funct7_5D),
    .ctrl     (d_ctrl),
`ifdef CONTROL_ILLEGAL_TRAP_EN
    .illegal  (d_illegal),
`endif
    .imm_src  (imm_src)
  );

  always_comb begin
    e_next = '0;
    if (bus.validD) begin
      e_next       = d_ctrl;
      e_next.valid = 1'b1;
    end
  end

  // Flush wins over stall so a squashed slot can never be held.
  always_ff @(posedge clk) begin
    if (reset || bus.flushE) begin
      e_reg <= '0;
    end else if (!bus.stallE) begin
      e_reg <= e_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.stallE) begin
      m_valid      <= 1'b0;
      m_reg_write  <= 1'b0;
      m_mem_write  <= 1'b0;
      m_result_src <= RES_ALU;
    end else begin
      m_valid      <= e_reg.valid;
      m_reg_write  <= e_reg.reg_write;
      m_mem_write  <= e_reg.mem_write;
      m_result_src <= e_reg.result_src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid      <= 1'b0;
      w_reg_write  <= 1'b0;
      w_result_src <= RES_ALU;
    end else begin
      w_valid      <= m_valid;
      w_reg_write  <= m_reg_write;
      w_result_src <= m_result_src;
    end
  end

`ifdef CONTROL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset || bus.flushE) begin
      e_illegal <= 1'b0;
    end else if (!bus.stallE) begin
      e_illegal <= bus.validD & d_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen <= 1'b0;
    end else if (e_reg.valid && e_illegal) begin
      seen <= 1'b1;
    end
  end

  assign bus.illegalE     = e_reg.valid & e_illegal;
  assign bus.illegal_seen = seen;
`else
  assign bus.illegalE     = 1'b0;
  assign bus.illegal_seen = 1'b0;
`endif

  assign bus.imm_srcD     = imm_src;
  assign bus.validE       = e_reg.valid;
  assign bus.reg_writeE   = e_reg.reg_write;
  assign bus.alu_srcE     = e_reg.alu_src;
  assign bus.branchE      = e_reg.branch;
  assign bus.jumpE        = e_reg.jump;
  assign bus.jalrE        = e_reg.jalr;
  assign bus.funct3E      = e_reg.funct3;
  assign bus.alu_controlE = e_reg.alu_control[ALU_CTRL_W-1:0];
  assign bus.result_srcE  = e_reg.result_src;
  assign bus.validM       = m_valid;
  assign bus.reg_writeM   = m_reg_write;
  assign bus.mem_writeM   = m_mem_write;
  assign bus.result_srcM  = m_result_src;
  assign bus.validW       = w_valid;
  assign bus.reg_writeW   = w_reg_write;
  assign bus.result_srcW  = w_result_src;

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb/tb_control_unit_pipe.sv - scoreboard bench for control_unit_pipe (ALU_CTRL_W=4)
module tb_control_unit_pipe;
  import riscv_ctrl_pkg::*;

  localparam int W = 4;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_unit_pipe_if #(.ALU_CTRL_W(W)) bus ();
  control_unit_pipe #(.ALU_CTRL_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic       rw, mw, as, br, j, jr;
    logic [1:0] rs;
    logic [2:0] f3;
    logic [3:0] alu;
    logic       ill;
  } exp_t;

  exp_t qe[$];
  exp_t qm[$];
  exp_t qw[$];
  int checks = 0;
  int failures = 0;
  bit load_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit rw, mw, as, br, j, jr, input logic [1:0] rs,
                              input logic [2:0] f3, input logic [3:0] alu, input bit ill);
    exp_t e;
    e = '{rw, mw, as, br, j, jr, rs, f3, alu, ill};
    return e;
  endfunction

  // Monitor: pops an expectation whenever a new instruction shows up in E, M or W.
  always @(negedge clk) begin
    exp_t e;
    if (load_prev) begin
      if (qe.size() == 0) chk("e_unexpected", 1, 0);
      else begin
        e = qe.pop_front();
        chk("validE", bus.validE, 1);
        chk("reg_writeE", bus.reg_writeE, e.rw);
        chk("alu_srcE", bus.alu_srcE, e.as);
        chk("branchE", bus.branchE, e.br);
        chk("jumpE", bus.jumpE, e.j);
        chk("jalrE", bus.jalrE, e.jr);
        chk("result_srcE", bus.result_srcE, e.rs);
        chk("funct3E", bus.funct3E, e.f3);
        chk("alu_controlE", bus.alu_controlE, e.alu);
        chk("illegalE", bus.illegalE, e.ill);
      end
    end
    if (bus.validM === 1'b1) begin
      if (qm.size() == 0) chk("m_unexpected", 1, 0);
      else begin
        e = qm.pop_front();
        chk("reg_writeM", bus.reg_writeM, e.rw);
        chk("mem_writeM", bus.mem_writeM, e.mw);
        chk("result_srcM", bus.result_srcM, e.rs);
      end
    end
    if (bus.validW === 1'b1) begin
      if (qw.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        e = qw.pop_front();
        chk("reg_writeW", bus.reg_writeW, e.rw);
        chk("result_srcW", bus.result_srcW, e.rs);
      end
    end
    load_prev = !reset && !bus.flushE && !bus.stallE && bus.validD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit st, input bit fl);
    bus.validD = 1'b0;
    bus.stallE = st;
    bus.flushE = fl;
    tick();
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input exp_t e, input int imm);
    bus.validD    = 1'b1;
    bus.opD       = op;
    bus.funct3D   = f3;
    bus.funct7_5D = f75;
    bus.stallE    = 1'b0;
    bus.flushE    = 1'b0;
    #1;
    if (imm >= 0) chk("imm_srcD", bus.imm_srcD, imm);
    qe.push_back(e);
    qm.push_back(e);
    qw.push_back(e);
    tick();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_validE"}, bus.validE, 0);
    chk({tag, "_validM"}, bus.validM, 0);
    chk({tag, "_validW"}, bus.validW, 0);
    chk({tag, "_reg_writeE"}, bus.reg_writeE, 0);
    chk({tag, "_reg_writeM"}, bus.reg_writeM, 0);
    chk({tag, "_reg_writeW"}, bus.reg_writeW, 0);
    chk({tag, "_mem_writeM"}, bus.mem_writeM, 0);
    chk({tag, "_jumpE"}, bus.jumpE, 0);
    chk({tag, "_branchE"}, bus.branchE, 0);
    chk({tag, "_illegalE"}, bus.illegalE, 0);
    chk({tag, "_illegal_seen"}, bus.illegal_seen, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.validD = 1'b0; bus.opD = '0; bus.funct3D = '0; bus.funct7_5D = 1'b0;
    bus.stallE = 1'b0; bus.flushE = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_cleared("reset");

    // base sequence lw, sw, add, beq
    issue(OP_LOAD,   3'b010, 1'b0, mk(1,0,1,0,0,0,2'b01,3'b010,4'h0,0), 0);
    issue(OP_STORE,  3'b010, 1'b0, mk(0,1,1,0,0,0,2'b00,3'b010,4'h0,0), 1);
    issue(OP_RTYPE,  3'b000, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b000,4'h0,0), -1);
    issue(OP_BRANCH, 3'b000, 1'b0, mk(0,0,0,1,0,0,2'b00,3'b000,4'h1,0), 2);

    // ALU decode, extended set
    issue(OP_RTYPE, 3'b101, 1'b1, mk(1,0,0,0,0,0,2'b00,3'b101,4'h8,0), -1);
    issue(OP_RTYPE, 3'b101, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b101,4'h7,0), -1);
    issue(OP_IALU,  3'b000, 1'b1, mk(1,0,1,0,0,0,2'b00,3'b000,4'h0,0), 0);
    issue(OP_RTYPE, 3'b000, 1'b1, mk(1,0,0,0,0,0,2'b00,3'b000,4'h1,0), -1);
    issue(OP_RTYPE, 3'b010, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b010,4'h5,0), -1);
    issue(OP_IALU,  3'b110, 1'b0, mk(1,0,1,0,0,0,2'b00,3'b110,4'h3,0), 0);
    issue(OP_RTYPE, 3'b111, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b111,4'h2,0), -1);
    issue(OP_RTYPE, 3'b100, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b100,4'h4,0), -1);
    issue(OP_RTYPE, 3'b001, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b001,4'h6,0), -1);
    issue(OP_RTYPE, 3'b011, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b011,4'h9,0), -1);
    issue(OP_JAL,   3'b000, 1'b0, mk(1,0,0,0,1,0,2'b10,3'b000,4'h0,0), 3);
    issue(OP_JALR,  3'b000, 1'b0, mk(1,0,1,0,1,1,2'b10,3'b000,4'h0,0), 0);
    idle(0, 0);
    chk("bubble_validE", bus.validE, 0);
    chk("bubble_reg_writeE", bus.reg_writeE, 0);

    // stall two cycles with a sub in E
    issue(OP_RTYPE, 3'b000, 1'b1, mk(1,0,0,0,0,0,2'b00,3'b000,4'h1,0), -1);
    bus.validD = 1'b1; bus.opD = OP_LOAD; bus.funct3D = 3'b010; bus.stallE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_validE", bus.validE, 1);
      chk("stall_reg_writeE", bus.reg_writeE, 1);
      chk("stall_alu_controlE", bus.alu_controlE, 4'h1);
      chk("stall_validM", bus.validM, 0);
      chk("stall_reg_writeM", bus.reg_writeM, 0);
    end
    idle(0, 0);
    chk("unstall_validM", bus.validM, 1);
    chk("unstall_reg_writeM", bus.reg_writeM, 1);
    idle(0, 0);

    // flush beats stall
    bus.validD = 1'b1; bus.opD = OP_JAL; bus.funct3D = 3'b000;
    bus.stallE = 1'b1; bus.flushE = 1'b1;
    tick();
    chk("flush_validE", bus.validE, 0);
    chk("flush_jumpE", bus.jumpE, 0);
    chk("flush_reg_writeE", bus.reg_writeE, 0);
    idle(0, 0);
    idle(0, 0);

    // illegal opcode and sticky flag
    issue(7'b1111111, 3'b000, 1'b0, mk(0,0,0,0,0,0,2'b00,3'b000,4'h0,TRAP), -1);
    chk("illegal_seen_not_yet", bus.illegal_seen, 0);
    issue(OP_RTYPE, 3'b000, 1'b0, mk(1,0,0,0,0,0,2'b00,3'b000,4'h0,0), -1);
    chk("illegal_seen_set", bus.illegal_seen, TRAP);
    issue(OP_LOAD, 3'b010, 1'b0, mk(1,0,1,0,0,0,2'b01,3'b010,4'h0,0), 0);
    idle(0, 0);
    idle(0, 0);
    chk("illegal_seen_held", bus.illegal_seen, TRAP);

    // reset with E/M/W all occupied
    issue(OP_LOAD,  3'b010, 1'b0, mk(1,0,1,0,0,0,2'b01,3'b010,4'h0,0), 0);
    issue(OP_STORE, 3'b010, 1'b0, mk(0,1,1,0,0,0,2'b00,3'b010,4'h0,0), 1);
    issue(OP_JAL,   3'b000, 1'b0, mk(1,0,0,0,1,0,2'b10,3'b000,4'h0,0), 3);
    reset = 1'b1;
    bus.validD = 1'b0;
    tick();
    check_cleared("midreset");
    qe.delete();
    qm.delete();
    qw.delete();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle(0, 0);
    chk("qe_drained", qe.size(), 0);
    chk("qm_drained", qm.size(), 0);
    chk("qw_drained", qw.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
